// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALUOp encodings, writeback/destination selects,
// datapath width defaults and the bubble values used by the pipeline registers.
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_FUNCT = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam int         OP_UNSIGNED = 3;

  typedef enum logic [1:0] {
    REG_DST_RT  = 2'b00,
    REG_DST_RD  = 2'b01,
    REG_DST_R31 = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    MEM_TO_REG_ALU = 2'b00,
    MEM_TO_REG_MEM = 2'b01,
    MEM_TO_REG_PC4 = 2'b10
  } mem_to_reg_e;

  // A bubble is all-zero: signed add with every enable off has no architectural effect.
  localparam logic [3:0] BUBBLE_ALU_OP     = {1'b0, OP_ADD};
  localparam logic [1:0] BUBBLE_REG_DST    = REG_DST_RT;
  localparam logic [1:0] BUBBLE_MEM_TO_REG = MEM_TO_REG_ALU;
  localparam logic       BUBBLE_VALID      = 1'b0;
  localparam logic       BUBBLE_ENABLE     = 1'b0;

endpackage

// File: rtl/id_ex_bypass.sv
// Writeback bypass for one operand: substitutes the WB data when WB is writing
// the same nonzero register address.
module id_ex_bypass #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_write_addr_i,
  input  logic [DATA_W-1:0] wb_write_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic hit;

  // $zero is hardwired, so a WB to address 0 must never leak into an operand.
  assign hit    = wb_reg_write_i && (wb_write_addr_i != '0) && (wb_write_addr_i == addr_i);
  assign data_o = hit ? wb_write_data_i : data_i;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall (hold), flush (bubble) and a writeback
// bypass that also refreshes held operands during a stall.
module id_ex_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [3:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic [4:0]        id_shamt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_alu_src1,
  input  logic              id_alu_src2,
  input  logic [1:0]        id_reg_dst,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic [1:0]        id_mem_to_reg,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_addr,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [3:0]        ex_alu_op,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_shamt,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_alu_src1,
  output logic              ex_alu_src2,
  output logic [1:0]        ex_reg_dst,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic [1:0]        ex_mem_to_reg
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_plus4_q, pc_plus4_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [5:0]        funct_q, funct_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_ext_q, imm_ext_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              alu_src1_q, alu_src1_d;
  logic              alu_src2_q, alu_src2_d;
  logic [1:0]        reg_dst_q, reg_dst_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              reg_write_q, reg_write_d;
  logic [1:0]        mem_to_reg_q, mem_to_reg_d;

  logic              holding;
  logic [REG_AW-1:0] rs_addr_sel, rt_addr_sel;
  logic [DATA_W-1:0] rs_data_sel, rt_data_sel;
  logic [DATA_W-1:0] rs_bypassed, rt_bypassed;

  // One bypass per operand serves both paths: incoming ID operands on a load,
  // the held EX operands while stalled.
  assign holding     = stall && !flush;
  assign rs_addr_sel = holding ? rs_q      : id_rs;
  assign rt_addr_sel = holding ? rt_q      : id_rt;
  assign rs_data_sel = holding ? rs_data_q : id_rs_data;
  assign rt_data_sel = holding ? rt_data_q : id_rt_data;

  id_ex_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_bypass (
    .addr_i          (rs_addr_sel),
    .data_i          (rs_data_sel),
    .wb_reg_write_i  (wb_reg_write),
    .wb_write_addr_i (wb_write_addr),
    .wb_write_data_i (wb_write_data),
    .data_o          (rs_bypassed)
  );

  id_ex_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_bypass (
    .addr_i          (rt_addr_sel),
    .data_i          (rt_data_sel),
    .wb_reg_write_i  (wb_reg_write),
    .wb_write_addr_i (wb_write_addr),
    .wb_write_data_i (wb_write_data),
    .data_o          (rt_bypassed)
  );

  always_comb begin
    valid_d      = valid_q;
    pc_plus4_d   = pc_plus4_q;
    alu_op_d     = alu_op_q;
    funct_d      = funct_q;
    shamt_d      = shamt_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_ext_d    = imm_ext_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    alu_src1_d   = alu_src1_q;
    alu_src2_d   = alu_src2_q;
    reg_dst_d    = reg_dst_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (flush) begin
      valid_d      = BUBBLE_VALID;
      pc_plus4_d   = '0;
      alu_op_d     = BUBBLE_ALU_OP;
      funct_d      = '0;
      shamt_d      = '0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_ext_d    = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      alu_src1_d   = BUBBLE_ENABLE;
      alu_src2_d   = BUBBLE_ENABLE;
      reg_dst_d    = BUBBLE_REG_DST;
      mem_read_d   = BUBBLE_ENABLE;
      mem_write_d  = BUBBLE_ENABLE;
      reg_write_d  = BUBBLE_ENABLE;
      mem_to_reg_d = BUBBLE_MEM_TO_REG;
    end else if (!stall) begin
      valid_d      = id_valid;
      pc_plus4_d   = id_pc_plus4;
      alu_op_d     = id_alu_op;
      funct_d      = id_funct;
      shamt_d      = id_shamt;
      rs_data_d    = rs_bypassed;
      rt_data_d    = rt_bypassed;
      imm_ext_d    = id_imm_ext;
      rs_d         = id_rs;
      rt_d         = id_rt;
      rd_d         = id_rd;
      alu_src1_d   = id_alu_src1;
      alu_src2_d   = id_alu_src2;
      reg_dst_d    = id_reg_dst;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      reg_write_d  = id_reg_write;
      mem_to_reg_d = id_mem_to_reg;
    end else if (valid_q) begin
      rs_data_d = rs_bypassed;
      rt_data_d = rt_bypassed;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= BUBBLE_VALID;
      pc_plus4_q   <= '0;
      alu_op_q     <= BUBBLE_ALU_OP;
      funct_q      <= '0;
      shamt_q      <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_ext_q    <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alu_src1_q   <= BUBBLE_ENABLE;
      alu_src2_q   <= BUBBLE_ENABLE;
      reg_dst_q    <= BUBBLE_REG_DST;
      mem_read_q   <= BUBBLE_ENABLE;
      mem_write_q  <= BUBBLE_ENABLE;
      reg_write_q  <= BUBBLE_ENABLE;
      mem_to_reg_q <= BUBBLE_MEM_TO_REG;
    end else begin
      valid_q      <= valid_d;
      pc_plus4_q   <= pc_plus4_d;
      alu_op_q     <= alu_op_d;
      funct_q      <= funct_d;
      shamt_q      <= shamt_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_ext_q    <= imm_ext_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      alu_src1_q   <= alu_src1_d;
      alu_src2_q   <= alu_src2_d;
      reg_dst_q    <= reg_dst_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc_plus4   = pc_plus4_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_funct      = funct_q;
  assign ex_shamt      = shamt_q;
  assign ex_rs_data    = rs_data_q;
  assign ex_rt_data    = rt_data_q;
  assign ex_imm_ext    = imm_ext_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_alu_src1   = alu_src1_q;
  assign ex_alu_src2   = alu_src2_q;
  assign ex_reg_dst    = reg_dst_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, WB bypass, stall refresh,
// flush-over-stall priority and back-to-back loads.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        id_valid;
  logic [31:0] id_pc_plus4;
  logic [3:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_alu_src1, id_alu_src2;
  logic [1:0]  id_reg_dst;
  logic        id_mem_read, id_mem_write, id_reg_write;
  logic [1:0]  id_mem_to_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic        ex_valid;
  logic [31:0] ex_pc_plus4;
  logic [3:0]  ex_alu_op;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_shamt;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_alu_src1, ex_alu_src2;
  logic [1:0]  ex_reg_dst;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;
  logic [1:0]  ex_mem_to_reg;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc_plus4(id_pc_plus4), .id_alu_op(id_alu_op),
    .id_funct(id_funct), .id_shamt(id_shamt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .id_alu_src1(id_alu_src1),
    .id_alu_src2(id_alu_src2), .id_reg_dst(id_reg_dst),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr),
    .wb_write_data(wb_write_data),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_alu_op(ex_alu_op),
    .ex_funct(ex_funct), .ex_shamt(ex_shamt), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_alu_src1(ex_alu_src1),
    .ex_alu_src2(ex_alu_src2), .ex_reg_dst(ex_reg_dst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    stall = 0; flush = 0; id_valid = 0; id_pc_plus4 = '0; id_alu_op = '0;
    id_funct = '0; id_shamt = '0; id_rs_data = '0; id_rt_data = '0;
    id_imm_ext = '0; id_rs = '0; id_rt = '0; id_rd = '0; id_alu_src1 = 0;
    id_alu_src2 = 0; id_reg_dst = '0; id_mem_read = 0; id_mem_write = 0;
    id_reg_write = 0; id_mem_to_reg = '0; wb_reg_write = 0;
    wb_write_addr = '0; wb_write_data = '0;
  endtask

  task automatic test_reset();
    reset = 1; clearInputs();
    tick(); tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", ex_valid); end
    total++; if (ex_alu_op !== 4'b0000) begin bad++; $display("[TB] FAIL reset_alu_op got=%b exp=0000", ex_alu_op); end
    reset = 0;
    id_valid = 1; id_reg_write = 1; id_alu_op = 4'b1011; id_pc_plus4 = 32'h20;
    tick();
    total++; if (ex_reg_write !== 1'b1) begin bad++; $display("[TB] FAIL preload_reg_write got=%0b exp=1", ex_reg_write); end
    #2 reset = 1;
    #1;
    total++; if (ex_reg_write !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_reg_write got=%0b exp=0", ex_reg_write); end
    total++; if (ex_alu_op !== 4'b0000) begin bad++; $display("[TB] FAIL async_reset_alu_op got=%b exp=0000", ex_alu_op); end
    total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_valid got=%0b exp=0", ex_valid); end
    total++; if (ex_pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL async_reset_pc got=%h exp=0", ex_pc_plus4); end
    #2 reset = 0;
    clearInputs();
  endtask

  task automatic test_load();
    clearInputs();
    id_valid = 1; id_pc_plus4 = 32'h100; id_alu_op = 4'b0010; id_funct = 6'h20;
    id_shamt = 5'd3; id_rs_data = 32'h5; id_rt_data = 32'h6; id_imm_ext = 32'hFFFF_FFF0;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_alu_src2 = 1; id_reg_dst = 2'b01;
    id_mem_to_reg = 2'b10; id_reg_write = 1; id_mem_read = 1;
    tick();
    total++; if (ex_alu_op !== 4'b0010) begin bad++; $display("[TB] FAIL load_alu_op got=%b exp=0010", ex_alu_op); end
    total++; if (ex_funct !== 6'h20) begin bad++; $display("[TB] FAIL load_funct got=%h exp=20", ex_funct); end
    total++; if (ex_rs_data !== 32'h5) begin bad++; $display("[TB] FAIL load_rs_data got=%h exp=5", ex_rs_data); end
    total++; if (ex_rt_data !== 32'h6) begin bad++; $display("[TB] FAIL load_rt_data got=%h exp=6", ex_rt_data); end
    total++; if (ex_imm_ext !== 32'hFFFF_FFF0) begin bad++; $display("[TB] FAIL load_imm got=%h exp=fffffff0", ex_imm_ext); end
    total++; if ({ex_rs, ex_rt, ex_rd, ex_shamt} !== {5'd1, 5'd2, 5'd3, 5'd3}) begin bad++; $display("[TB] FAIL load_addrs got=%0d/%0d/%0d/%0d exp=1/2/3/3", ex_rs, ex_rt, ex_rd, ex_shamt); end
    total++; if ({ex_alu_src1, ex_alu_src2, ex_reg_dst, ex_mem_to_reg} !== 6'b01_01_10) begin bad++; $display("[TB] FAIL load_selects got=%b exp=010110", {ex_alu_src1, ex_alu_src2, ex_reg_dst, ex_mem_to_reg}); end
    total++; if ({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write} !== 4'b1101) begin bad++; $display("[TB] FAIL load_enables got=%b exp=1101", {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write}); end
    // Invalid slot registers as given; enables are not masked.
    id_valid = 0;
    tick();
    total++; if ({ex_valid, ex_reg_write} !== 2'b01) begin bad++; $display("[TB] FAIL invalid_slot got=%b exp=01", {ex_valid, ex_reg_write}); end
  endtask

  task automatic test_bypass();
    clearInputs();
    id_valid = 1; id_rs = 5'd8; id_rs_data = 32'h1; id_rt = 5'd3; id_rt_data = 32'h33;
    wb_reg_write = 1; wb_write_addr = 5'd8; wb_write_data = 32'hABCD;
    tick();
    total++; if (ex_rs_data !== 32'hABCD) begin bad++; $display("[TB] FAIL bypass_rs got=%h exp=abcd", ex_rs_data); end
    total++; if (ex_rt_data !== 32'h33) begin bad++; $display("[TB] FAIL bypass_rt_nomatch got=%h exp=33", ex_rt_data); end
    id_rs = 5'd0; wb_write_addr = 5'd0;
    tick();
    total++; if (ex_rs_data !== 32'h1) begin bad++; $display("[TB] FAIL bypass_addr0 got=%h exp=1", ex_rs_data); end
    id_rs = 5'd12; id_rt = 5'd12; id_rs_data = 32'h1; id_rt_data = 32'h2;
    wb_write_addr = 5'd12; wb_write_data = 32'h5A;
    tick();
    total++; if ({ex_rs_data, ex_rt_data} !== {32'h5A, 32'h5A}) begin bad++; $display("[TB] FAIL bypass_both got=%h/%h exp=5a/5a", ex_rs_data, ex_rt_data); end
    wb_reg_write = 0;
    tick();
    total++; if ({ex_rs_data, ex_rt_data} !== {32'h1, 32'h2}) begin bad++; $display("[TB] FAIL bypass_wb_off got=%h/%h exp=1/2", ex_rs_data, ex_rt_data); end
  endtask

  task automatic test_stall_refresh();
    clearInputs();
    id_valid = 1; id_pc_plus4 = 32'h40; id_rs = 5'd4; id_rs_data = 32'h44;
    id_rt = 5'd9; id_rt_data = 32'h11; id_reg_write = 1;
    tick();
    stall = 1;
    id_pc_plus4 = 32'hDEAD; id_rs_data = 32'hBAD; id_rt_data = 32'hBAD; id_rs = 5'd7;
    tick();
    total++; if ({ex_pc_plus4, ex_rt_data} !== {32'h40, 32'h11}) begin bad++; $display("[TB] FAIL stall_hold1 got=%h/%h exp=40/11", ex_pc_plus4, ex_rt_data); end
    wb_reg_write = 1; wb_write_addr = 5'd9; wb_write_data = 32'h77;
    tick();
    total++; if (ex_rt_data !== 32'h77) begin bad++; $display("[TB] FAIL stall_refresh_rt got=%h exp=77", ex_rt_data); end
    total++; if ({ex_pc_plus4, ex_rs_data, ex_rs} !== {32'h40, 32'h44, 5'd4}) begin bad++; $display("[TB] FAIL stall_refresh_hold got=%h/%h/%0d exp=40/44/4", ex_pc_plus4, ex_rs_data, ex_rs); end
    wb_reg_write = 0;
    tick();
    total++; if ({ex_rt_data, ex_valid, ex_reg_write} !== {32'h77, 2'b11}) begin bad++; $display("[TB] FAIL stall_hold3 got=%h/%b exp=77/11", ex_rt_data, {ex_valid, ex_reg_write}); end
    stall = 0;
  endtask

  task automatic test_stall_flush();
    clearInputs();
    id_valid = 1; id_mem_write = 1; id_pc_plus4 = 32'h80;
    tick();
    total++; if (ex_mem_write !== 1'b1) begin bad++; $display("[TB] FAIL pre_flush_mem_write got=%0b exp=1", ex_mem_write); end
    stall = 1; flush = 1;
    tick();
    total++; if ({ex_mem_write, ex_valid, ex_pc_plus4} !== {2'b00, 32'h0}) begin bad++; $display("[TB] FAIL flush_over_stall got=%b/%h exp=00/0", {ex_mem_write, ex_valid}, ex_pc_plus4); end
    clearInputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] expPc [3] = '{32'h4, 32'h8, 32'hC};
    clearInputs();
    id_valid = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc_plus4 = 32'(4 * (i + 1));
      tick();
      total++; if (ex_pc_plus4 !== expPc[i]) begin bad++; $display("[TB] FAIL back_to_back_%0d got=%h exp=%h", i, ex_pc_plus4, expPc[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_bypass();
    test_stall_refresh();
    test_stall_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Captures decoded control and operands from the decode stage and presents them to the execute stage: ALU control decode, ALU, and forwarding muxes.
- Supports stall (hold), flush (bubble insertion) and a same-cycle writeback bypass, so a register written in WB is never read stale.

Parameters:
- DATA_W, 32, datapath width (register data, PC, immediate)
- REG_AW, 5, register address width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold current contents (load-use hazard)
- flush  in  1  load a bubble (branch/jump taken)
- id_valid  in  1  decode slot holds a real instruction
- id_pc_plus4  in  DATA_W  PC+4 of decoded instruction
- id_alu_op  in  4  ALUOp; bit3=unsigned, bits[2:0] select add/sub/funct/or/and/slt
- id_funct  in  6  instruction funct field
- id_shamt  in  5  shift amount
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- id_imm_ext  in  DATA_W  extended immediate
- id_rs, id_rt, id_rd  in  REG_AW  register addresses
- id_alu_src1, id_alu_src2  in  1  operand select (shamt / immediate)
- id_reg_dst  in  2  dest select (rt/rd/r31)
- id_mem_read, id_mem_write, id_reg_write  in  1  memory/writeback enables
- id_mem_to_reg  in  2  writeback source select
- wb_reg_write  in  1  writeback enable from WB stage
- wb_write_addr  in  REG_AW  writeback register
- wb_write_data  in  DATA_W  writeback data
- ex_*  out  (same widths)  registered copies of every id_* field, plus ex_valid

Behaviour:
- Reset (async, active-high): every ex_* output goes to the bubble value immediately, independent of clk.
- Bubble value: all fields 0. This gives ex_valid=0, reg_write/mem_read/mem_write=0 and alu_op=4'b0000 (signed add). The execute stage therefore has no architectural effect.
- Latency: 1 cycle. The id_* value sampled at edge N appears on ex_* after edge N.
- Priority per edge: reset > flush > stall > load.
  - flush=1: load bubble, even if stall=1.
  - stall=1, flush=0: hold all fields, except the bypass refresh below.
  - else: load id_* fields.
- Writeback bypass on load: if wb_reg_write=1, wb_write_addr!=0 and wb_write_addr==id_rs, capture wb_write_data into ex_rs_data instead of id_rs_data. Same rule applies for rt / ex_rt_data. Address 0 is never bypassed.
- Refresh while stalled: if stall=1, flush=0, ex_valid=1, wb_reg_write=1, wb_write_addr!=0 and it equals ex_rs (ex_rt), replace ex_rs_data (ex_rt_data) with wb_write_data. Other fields hold. This keeps operands current during multi-cycle stalls.
- Both rs and rt matching the same WB address: both are bypassed.
- id_valid=0 on load: register it as given. Control enables are not masked here; decode already zeros them.
- No combinational path from any id_* input to any ex_* output.
- Reset deasserting mid-stall: first edge after release obeys the normal priority.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - ALUOp encodings: OP_ADD=000, OP_SUB=001, OP_FUNCT=010, OP_OR=011, OP_AND=100, OP_SLT=101, and the OP_UNSIGNED bit position (3)
  - reg_dst and mem_to_reg select encodings
  - BUBBLE constants
  - DATA_W/REG_AW defaults
- One sub-module: id_ex_bypass. Combinational; takes a register address, its current data and the WB port, and returns the bypassed data. It is instantiated twice (rs, rt) and shared by the load and refresh paths.

Test Plan:
- Reset asserted mid-cycle with ex_reg_write=1 -> ex_reg_write=0, ex_alu_op=0, ex_valid=0 before the next edge.
- Load id_alu_op=4'b0010, id_funct=6'h20, id_rs_data=32'h5 -> after one edge ex_alu_op=4'b0010, ex_funct=6'h20, ex_rs_data=32'h5.
- Load with id_rs=5'd8, id_rs_data=32'h1, wb_reg_write=1, wb_write_addr=8, wb_write_data=32'hABCD -> ex_rs_data=32'hABCD. Repeat with addr 0 -> ex_rs_data=32'h1.
- stall=1 for 3 cycles with ex_rt=9, WB writes reg 9 = 32'h77 in cycle 2 -> all fields hold, ex_rt_data becomes 32'h77 after that edge.
- stall=1 and flush=1 on the same edge with ex_mem_write=1 -> bubble: ex_mem_write=0, ex_valid=0.
- Back-to-back loads of three instructions, no stall/flush -> ex_pc_plus4 sequence 0x4, 0x8, 0xC on consecutive edges.
